// File: rtl/microwave_controller_gen.sv
// Microwave controller: loads cook time and power level, counts down in seconds
// derived from clk, duty-cycles the magnetron by level and raises a timed beep.
module microwave_controller_gen #(
    parameter int  TIME_W      = 10,
    parameter int  CLK_PER_SEC = 50000000,
    parameter int  N_LEVELS    = 4,
    parameter int  ADD_SEC     = 30,
    parameter int  BEEP_SECS   = 3,
    localparam int LVL_W       = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              door_closed,
    input  logic              start,
    input  logic              cancel,
    input  logic              add_time,
    input  logic              load,
    input  logic [TIME_W-1:0] time_in,
    input  logic [LVL_W-1:0]  power_level,
    output logic              magnetron_on,
    output logic              light_on,
    output logic              beep,
    output logic              busy,
    output logic [TIME_W-1:0] time_left,
    output logic [6:0]        state_display1,
    output logic [6:0]        state_display2,
    output logic [6:0]        state_display3,
    output logic [6:0]        state_display4
);

    localparam int PRE_W    = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam int BEEP_CYC = BEEP_SECS * CLK_PER_SEC;
    localparam int BEEP_W   = (BEEP_CYC > 0) ? $clog2(BEEP_CYC + 1) : 1;

    localparam logic [TIME_W-1:0] T_MAX   = '1;
    localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(N_LEVELS - 1);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(CLK_PER_SEC - 1);

    localparam logic [6:0] SEG_I = 7'b0110000, SEG_D = 7'b0111101, SEG_L = 7'b0001110,
                           SEG_E = 7'b1001111, SEG_R = 7'b0000101, SEG_Y = 7'b0111011,
                           SEG_P = 7'b1100111, SEG_O = 7'b1111110, SEG_C = 7'b1001110,
                           SEG_S = 7'b1011011, SEG_T = 7'b0001111, SEG_N = 7'b0010101;
    localparam logic [27:0] DISP_IDLE = {SEG_I, SEG_D, SEG_L, SEG_E};

    typedef enum logic [2:0] {S_IDLE, S_READY, S_COOK, S_PAUSED, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   tl_q, tl_d;
    logic [LVL_W-1:0]    lvl_q, lvl_d, ph_q, ph_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [BEEP_W-1:0]   bc_q, bc_d;
    logic [27:0]         disp_q, disp_d;
    logic                start_q, cancel_q, add_q, load_q;
    logic                ev_start, ev_cancel, ev_add, ev_load, tick, took_tick;
    logic [TIME_W:0]     sum;

    assign ev_start  = start & ~start_q;
    assign ev_cancel = cancel & ~cancel_q;
    assign ev_add    = add_time & ~add_q;
    assign ev_load   = load & ~load_q;
    assign tick      = (state_q == S_COOK) && (pre_q == PRE_MAX);
    assign sum       = {1'b0, tl_q} + (TIME_W+1)'(ADD_SEC);

    // Only the highest-priority event applicable to the current state acts.
    always_comb begin
        state_d   = state_q;
        tl_d      = tl_q;
        lvl_d     = lvl_q;
        took_tick = 1'b0;
        if (ev_cancel && state_q != S_IDLE) begin
            if (state_q == S_COOK) begin
                state_d = S_PAUSED;
            end else begin
                state_d = S_IDLE;
                tl_d    = '0;
            end
        end else if (!door_closed && (state_q == S_COOK || state_q == S_DONE)) begin
            state_d = (state_q == S_COOK) ? S_PAUSED : S_IDLE;
        end else if (ev_start && door_closed && state_q inside {S_IDLE, S_READY, S_PAUSED}) begin
            if (state_q == S_IDLE) begin
                tl_d  = TIME_W'(ADD_SEC);
                lvl_d = LVL_MAX;
            end
            state_d = S_COOK;
        end else if (ev_add && state_q != S_DONE) begin
            tl_d = sum[TIME_W] ? T_MAX : sum[TIME_W-1:0];
            if (state_q == S_IDLE) begin
                state_d = S_READY;
                lvl_d   = LVL_MAX;
            end
        end else if (ev_load && (state_q == S_IDLE || state_q == S_READY)) begin
            tl_d    = time_in;
            lvl_d   = (power_level > LVL_MAX) ? LVL_MAX : power_level;
            state_d = (time_in == '0) ? S_IDLE : S_READY;
        end else if (tick) begin
            took_tick = 1'b1;
            if (tl_q <= TIME_W'(1)) begin
                tl_d    = '0;
                state_d = S_DONE;
            end else begin
                tl_d = tl_q - TIME_W'(1);
            end
        end
    end

    always_comb begin
        pre_d = '0;
        if (state_q == S_COOK)
            pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
        else if (state_q == S_PAUSED)
            pre_d = pre_q;

        ph_d = ph_q;
        if (state_d inside {S_IDLE, S_READY, S_DONE})
            ph_d = '0;
        else if (took_tick)
            ph_d = (ph_q == LVL_MAX) ? '0 : ph_q + LVL_W'(1);

        bc_d = '0;
        if (state_d == S_DONE) begin
            if (state_q != S_DONE)
                bc_d = BEEP_W'(BEEP_CYC);
            else if (bc_q != '0)
                bc_d = bc_q - BEEP_W'(1);
        end

        case (state_d)
            S_READY:  disp_d = {SEG_R, SEG_E, SEG_D, SEG_Y};
            S_COOK:   disp_d = {SEG_P, SEG_R, SEG_O, SEG_C};
            S_PAUSED: disp_d = {SEG_S, SEG_T, SEG_O, SEG_P};
            S_DONE:   disp_d = {SEG_D, SEG_O, SEG_N, SEG_E};
            default:  disp_d = DISP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            tl_q     <= '0;
            lvl_q    <= '0;
            pre_q    <= '0;
            ph_q     <= '0;
            bc_q     <= '0;
            disp_q   <= DISP_IDLE;
            start_q  <= 1'b0;
            cancel_q <= 1'b0;
            add_q    <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tl_q     <= tl_d;
            lvl_q    <= lvl_d;
            pre_q    <= pre_d;
            ph_q     <= ph_d;
            bc_q     <= bc_d;
            disp_q   <= disp_d;
            start_q  <= start;
            cancel_q <= cancel;
            add_q    <= add_time;
            load_q   <= load;
        end
    end

    assign magnetron_on = (state_q == S_COOK) && (ph_q <= lvl_q) && door_closed;
    assign light_on     = ~door_closed || (state_q == S_COOK);
    assign beep         = (state_q == S_DONE) && (bc_q != '0);
    assign busy         = (state_q == S_COOK) || (state_q == S_PAUSED);
    assign time_left    = tl_q;
    assign {state_display1, state_display2, state_display3, state_display4} = disp_q;

endmodule

// File: doc/microwave_controller_gen.md
Name: microwave_controller_gen

Overview:
Parametrised next-generation microwave controller. Loads a cook time and power level, counts down in real seconds derived from the system clock, and duty-cycles the magnetron by power level. Supports pause/resume, +ADD_SEC quick-add and a timed done beep. Drives four 7-segment state letters plus a binary time_left for the existing time display path.

Parameters:
TIME_W, 10, width of time_in/time_left in seconds (max 2^TIME_W-1)
CLK_PER_SEC, 50000000, clk cycles per one-second tick (bench uses 4)
N_LEVELS, 4, number of power levels; LVL_W = $clog2(N_LEVELS), minimum 1
ADD_SEC, 30, seconds added by add_time and by quick start
BEEP_SECS, 3, seconds beep is asserted on entering DONE

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low; all state cleared on posedge clk while reset==0
door_closed  in  1  1 = door closed
start  in  1  start/resume button, level, sync to clk
cancel  in  1  cancel button, level
add_time  in  1  +ADD_SEC button, level
load  in  1  load time_in and power_level, level
time_in  in  TIME_W  requested cook time, seconds
power_level  in  LVL_W  0 = lowest, N_LEVELS-1 = full
magnetron_on  out  1  magnetron enable
light_on  out  1  cavity lamp
beep  out  1  done alert
busy  out  1  1 in COOK or PAUSED
time_left  out  TIME_W  remaining seconds
state_display1..4  out  7 each  letters, segment order abcdefg, bit6 = a

Behaviour:
- Reset (reset==0 at posedge): state IDLE, time_left 0, latched level 0, prescaler 0, phase 0, beep counter 0, all edge registers 0; outputs magnetron_on 0, beep 0, busy 0, light_on = ~door_closed, display "IdLE".
- start/cancel/add_time/load are rising-edge detected internally (one registered previous value each); an event acts on the posedge where the input is high and previous is low. Held buttons act once.
- States: IDLE, READY, COOK, PAUSED, DONE. Per-cycle priority: cancel > door open > start > add_time > load > tick.
- cancel: COOK -> PAUSED; PAUSED or READY -> IDLE, time_left = 0; DONE -> IDLE. No effect in IDLE.
- door_closed==0: COOK -> PAUSED same edge. DONE -> IDLE. start ignored while open.
- start: READY -> COOK; PAUSED -> COOK (resume, time_left and prescaler preserved); IDLE -> COOK with time_left = ADD_SEC, level = N_LEVELS-1 (quick start). Requires door_closed.
- add_time: in IDLE (-> READY, level = N_LEVELS-1), READY, COOK, PAUSED: time_left += ADD_SEC, saturating at 2^TIME_W-1. Ignored in DONE.
- load: IDLE or READY only. time_left = time_in, level = min(power_level, N_LEVELS-1). time_in==0 -> IDLE, else READY. Ignored in COOK/PAUSED/DONE.
- Prescaler: counts 0..CLK_PER_SEC-1 only in COOK; tick is the cycle it equals CLK_PER_SEC-1 (wraps to 0). Holds in PAUSED; cleared in IDLE/READY/DONE.
- Tick in COOK: time_left -= 1; phase = (phase+1) mod N_LEVELS. If time_left was 1, same edge: time_left = 0, state DONE. time_left never underflows.
- Magnetron: internal reg = (state==COOK) && (phase <= level); magnetron_on = reg & door_closed (combinational gating, off within the same cycle the door opens). Level N_LEVELS-1 = always on in COOK. Phase cleared on leaving COOK to IDLE/DONE, held in PAUSED.
- DONE: beep = 1 for exactly BEEP_SECS*CLK_PER_SEC cycles after entry (own counter), then 0; state stays DONE until cancel or door open. Re-entry restarts beep.
- light_on = ~door_closed || state==COOK. busy = COOK or PAUSED.
- Displays, registered from state: IDLE "IdLE", READY "rEdY", COOK "PrOC", PAUSED "StOP", DONE "dOnE". Codes: I 0110000, d 0111101, L 0001110, E 1001111, r 0000101, y 0111011, P 1100111, O 1111110, C 1001110, S 1011011, t 0001111, n 0010101.
- Reset mid-COOK: next edge fully IDLE, magnetron_on 0 that edge.

Test Plan:
(CLK_PER_SEC=4, N_LEVELS=4, ADD_SEC=30, BEEP_SECS=3)
- Reset, door closed, load time_in=3 level=3, start -> COOK, magnetron_on 1 continuously, time_left 3,2,1,0 at 4-cycle spacing, DONE on 12th cook cycle, beep high 12 cycles, display "dOnE".
- Load time_in=8 level=1, start -> magnetron_on on for 2 of every 4 seconds (phases 0,1 on; 2,3 off), DONE after 32 cycles.
- COOK with time_left=5, open door mid-second -> magnetron_on 0 same cycle, PAUSED "StOP", time_left frozen; close door, start -> resumes, DONE after remaining prescaler plus 4 more ticks.
- IDLE, door closed, press start with no load -> quick start time_left 30, full power; add_time at time_left=1010 (TIME_W=10) -> saturates 1023.
- cancel in COOK -> PAUSED; second cancel -> IDLE, time_left 0; cancel and door-open same cycle as start -> start ignored.
- start held high 20 cycles -> single event; reset low during COOK -> IdLE, all outputs at reset values next edge.
